// File: rtl/imm_instr_packer.sv
// imm_instr_packer
//   Program loader in front of an instruction-memory write port. Takes decoded
//   instruction fields (format, opcode, funct3, rd/rs1/rs2, 32-bit immediate),
//   re-packs them into RV32 I-type or S-type words and writes them to
//   consecutive IM word addresses starting at 0.
//
//   Format codes follow EXTOp: 2'b01 = I-type, 2'b10 = S-type. Any other code
//   is an error: the bundle is dropped and the sticky err flag is set.
//
//   Optional feature (compile-time macro IMM_RANGE_CHK_EN):
//     defined   - in_imm must fit a 12-bit signed value (in_imm[31:11] all
//                 equal); otherwise the bundle is dropped and err is set.
//     undefined - in_imm[11:0] is packed as-is; only a bad format sets err.
//
//   Handshake: a bundle transfers on a rising clk edge where in_valid and
//   in_ready are both 1. in_ready is high only in IDLE, when not full and not
//   during a start pulse. The bundle need only be stable up to that edge.
//
//   FSM: IDLE -> PACK -> WRITE -> IDLE. A bundle accepted at edge N is packed
//   and checked at edge N+1, so im_we is high for the single cycle after N+1;
//   count increments at the edge that leaves WRITE.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               pulse: abandon any bundle, count=0, err=0, go IDLE
//   in_valid/in_ready   field bundle handshake
//   in_fmt .. in_imm    field bundle
//   im_we/im_addr/im_wdata  IM write port; addr/data hold between writes
//   busy                FSM not in IDLE
//   full                count == DEPTH; blocks further acceptance
//   err                 sticky error flag
//   count               words written since reset or start

module imm_instr_packer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PACK  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;

  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_S = 2'b10;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  logic [1:0]        state_q, state_d;
  bundle_t           bun_q, bun_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;

  logic        full_w;
  logic        accept;
  logic [31:0] packed_word;
  logic        fmt_ok;
  logic        imm_ok;
  logic        check_ok;

  assign full_w   = (count_q == DEPTH_C);
  // start suppresses acceptance so a bundle offered alongside it is not taken.
  assign in_ready = (state_q == ST_IDLE) && !full_w && !start;
  assign accept   = in_valid && in_ready;

  // Word assembly from the held fields; unused fields (rd for S, rs2 for I)
  // simply do not appear in the respective encoding.
  always_comb begin
    packed_word = '0;
    fmt_ok      = 1'b0;
    case (bun_q.fmt)
      FMT_I: begin
        packed_word = {bun_q.imm[11:0], bun_q.rs1, bun_q.funct3, bun_q.rd, bun_q.opcode};
        fmt_ok      = 1'b1;
      end
      FMT_S: begin
        packed_word = {bun_q.imm[11:5], bun_q.rs2, bun_q.rs1, bun_q.funct3,
                       bun_q.imm[4:0], bun_q.opcode};
        fmt_ok      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHK_EN
  // Representable as 12-bit signed: bits 31..11 are all copies of the sign.
  assign imm_ok = (bun_q.imm[31:11] == {21{bun_q.imm[11]}});
`else
  logic unused_imm_hi;
  assign imm_ok        = 1'b1;
  assign unused_imm_hi = ^bun_q.imm[31:12];
`endif

  assign check_ok = fmt_ok && imm_ok;

  always_comb begin
    state_d    = state_q;
    bun_d      = bun_q;
    count_d    = count_q;
    err_d      = err_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    if (start) begin
      // Abandons any in-flight bundle; im_we_d stays 0 so nothing is written.
      state_d = ST_IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bun_d = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, rd: in_rd,
                      rs1: in_rs1, rs2: in_rs2, imm: in_imm};
            state_d = ST_PACK;
          end
        end
        ST_PACK: begin
          if (check_ok) begin
            // Address/data registers only change on a real write so they
            // hold their last values otherwise.
            im_wdata_d = packed_word;
            im_addr_d  = count_q[ADDR_W-1:0];
            im_we_d    = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          count_d = count_q + ONE_C;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bun_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      bun_q      <= bun_d;
      count_q    <= count_d;
      err_q      <= err_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign full     = full_w;
  assign err      = err_q;
  assign count    = count_q;

endmodule

// File: tb/tb_imm_instr_packer.sv
module tb_imm_instr_packer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_fmt = '0;
  logic [6:0]        in_opcode = '0;
  logic [2:0]        in_funct3 = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   count;

  always #5 clk = ~clk;

  imm_instr_packer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .full(full), .err(err), .count(count)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    bit          exp_write;
    logic [31:0] exp_wdata;
  } vec_t;

  // Expected writes as {addr, wdata}
  logic [ADDR_W+31:0] exp_q[$];
  int model_count = 0;
  bit model_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_valid(input bundle_t b);
    bit ok;
    ok = (b.fmt == 2'b01) || (b.fmt == 2'b10);
`ifdef IMM_RANGE_CHK_EN
    if ($signed(b.imm) < -2048 || $signed(b.imm) > 2047) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] model_word(input bundle_t b);
    int unsigned imm12, w;
    imm12 = b.imm & 32'hFFF;
    if (b.fmt == 2'b01)
      w = (imm12 << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | (32'(b.rd) << 7) | 32'(b.op);
    else
      w = ((imm12 >> 5) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
          | ((imm12 & 31) << 7) | 32'(b.op);
    return w;
  endfunction

  task automatic model_accept(input bundle_t b);
    if (model_valid(b)) begin
      exp_q.push_back({ADDR_W'(model_count), model_word(b)});
      model_count++;
    end else begin
      model_err = 1'b1;
    end
  endtask

  // ---------------- scoreboard: every im_we pulse ----------------
  always @(negedge clk) begin
    if (!rst && im_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr=0x%0h wdata=0x%0h required=no write", im_addr, im_wdata);
      end else begin
        check("im_write", {im_addr, im_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a negedge; returns on the negedge after the accept edge
  // (DUT then in PACK) or after a bounded number of cycles.
  task automatic send(input bundle_t b, output bit accepted);
    in_fmt = b.fmt; in_opcode = b.op; in_funct3 = b.f3;
    in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    model_count = 0;
    model_err = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL idle_timeout: busy=%0b required=0", busy);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 64'(count), 64'(model_count));
    check({tag, "_err"}, 64'(err), 64'(model_err));
    check({tag, "_full"}, 64'(full), 64'(model_count == DEPTH));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic bundle_t mk(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.f3 = f3; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int sel;
    sel = $urandom_range(0, 9);
    b.fmt = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b11;
    b.op  = 7'($urandom);
    b.f3  = 3'($urandom);
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.imm = ($urandom_range(0, 2) == 0) ? $urandom : 32'($signed(12'($urandom)));
    return b;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[5];

  initial begin
    bit acc;
    bundle_t b;
    int n;

    vecs[0] = '{b: mk(2'b01, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5),       exp_write: 1'b1, exp_wdata: 32'h00500093};
    vecs[1] = '{b: mk(2'b10, 7'h23, 3'd2, 5'd0, 5'd0, 5'd2, 32'd8),       exp_write: 1'b1, exp_wdata: 32'h00202423};
    vecs[2] = '{b: mk(2'b11, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5),       exp_write: 1'b0, exp_wdata: 32'h0};
    vecs[3] = '{b: mk(2'b01, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF), exp_write: 1'b1, exp_wdata: 32'hFFF00093};
`ifdef IMM_RANGE_CHK_EN
    vecs[4] = '{b: mk(2'b01, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048),    exp_write: 1'b0, exp_wdata: 32'h0};
`else
    vecs[4] = '{b: mk(2'b01, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048),    exp_write: 1'b1, exp_wdata: 32'h80000093};
`endif

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_im_we", 64'(im_we), 64'd0);
    check("rst_im_addr", 64'(im_addr), 64'd0);
    check("rst_im_wdata", 64'(im_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Table-driven spec vectors, including latency on the first one
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].b, acc);
      check($sformatf("vec%0d_accepted", i), 64'(acc), 64'd1);
      if (vecs[i].exp_write) begin
        exp_q.push_back({ADDR_W'(model_count), vecs[i].exp_wdata});
        model_count++;
      end else begin
        model_err = 1'b1;
      end
      if (i == 0) begin
        check("lat_pack_we", 64'(im_we), 64'd0);
        check("lat_pack_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("lat_write_we", 64'(im_we), 64'd1);
        check("lat_write_ready", 64'(in_ready), 64'd0);
      end
      wait_idle();
      check_state($sformatf("vec%0d", i));
    end

    // Bundle offered during start is not accepted; start clears err/count
    in_fmt = 2'b01; in_opcode = 7'h13; in_valid = 1'b1;
    start = 1'b1;
    #1;
    check("start_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    model_count = 0; model_err = 1'b0;
    check("start_busy", 64'(busy), 64'd0);
    check_state("after_start");

    // Stream DEPTH bundles back-to-back, then verify full blocks a 5th
    for (int i = 0; i < DEPTH; i++) begin
      b = rand_bundle();
      b.fmt = (i % 2 == 0) ? 2'b01 : 2'b10;
      b.imm = 32'($signed(12'($urandom)));
      send(b, acc);
      check("stream_accepted", 64'(acc), 64'd1);
      model_accept(b);
    end
    wait_idle();
    check_state("stream");
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    send(mk(2'b01, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1), acc);
    check("full_reject", 64'(acc), 64'd0);
    check_state("full_hold");
    do_start();
    check_state("full_cleared");

    // start while in PACK: bundle discarded, no write
    send(mk(2'b01, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 32'd7), acc);
    check("abort_accepted", 64'(acc), 64'd1);
    do_start();
    repeat (3) @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check_state("abort");

    // rst one cycle before WRITE: everything back to zero, no write
    b = mk(2'b10, 7'h23, 3'd2, 5'd0, 5'd5, 5'd6, 32'd12);
    send(b, acc);
    model_accept(b);
    wait_idle();
    send(mk(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1), acc);
    model_err = 1'b1;
    wait_idle();
    check_state("pre_rst");
    send(mk(2'b01, 7'h13, 3'd0, 5'd9, 5'd8, 5'd0, 32'd100), acc);
    check("rst_test_accepted", 64'(acc), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_im_we", 64'(im_we), 64'd0);
    check("midrst_im_addr", 64'(im_addr), 64'd0);
    check("midrst_im_wdata", 64'(im_wdata), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_count = 0; model_err = 1'b0;
    repeat (3) @(negedge clk);
    check_state("post_rst");

    // Randomized rounds against the model
    for (int r = 0; r < 30; r++) begin
      do_start();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        b = rand_bundle();
        send(b, acc);
        check("rand_accepted", 64'(acc), 64'd1);
        if (acc) model_accept(b);
        wait_idle();
        check_state("rand");
      end
    end

    repeat (3) @(negedge clk);
    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
